// File: rtl/omsp_tsc_reader_pkg.sv
// Shared constants for the TSC reader initiator and the TSC peripheral decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package omsp_tsc_pkg;

  // Reader FSM state encoding (3 bits, kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SNAP = 3'd1;
  localparam logic [2:0] ST_RD0  = 3'd2;
  localparam logic [2:0] ST_RD1  = 3'd3;
  localparam logic [2:0] ST_RD2  = 3'd4;
  localparam logic [2:0] ST_RD3  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // TSC register word offsets; word 0 doubles as the snapshot trigger register
  localparam logic [1:0] TSC_OFS_W0 = 2'd0;
  localparam logic [1:0] TSC_OFS_W1 = 2'd1;
  localparam logic [1:0] TSC_OFS_W2 = 2'd2;
  localparam logic [1:0] TSC_OFS_W3 = 2'd3;

  // Default byte base address of the TSC block and the (ignored) snapshot data
  localparam logic [14:0] TSC_BASE_ADDR_DFLT = 15'h0190;
  localparam logic [15:0] TSC_SNAP_DATA      = 16'h0000;

  // Word offset read in a given RDk state
  function automatic logic [1:0] rd_word(input logic [2:0] st);
    logic [2:0] w_diff;
    w_diff = st - ST_RD0;
    return w_diff[1:0];
  endfunction

endpackage

// File: rtl/omsp_tsc_reader_if.sv
// openMSP430 peripheral bus slice used by the TSC reader (initiator side = master).
// Latency: combinational wires only.
// Backpressure: bus_gnt from the external arbiter gates all initiator activity.
interface omsp_tsc_reader_if;
  logic        bus_gnt;
  logic [15:0] per_dout;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;

  modport master (
    input  bus_gnt,
    input  per_dout,
    output per_addr,
    output per_din,
    output per_en,
    output per_we
  );

  modport slave (
    input  bus_gnt,
    input  per_addr,
    input  per_din,
    input  per_en,
    input  per_we,
    output per_dout
  );
endinterface

// File: rtl/omsp_tsc_reader.sv
// Fetches a coherent 64-bit TSC snapshot: one snapshot write, four word reads, assemble.
// Latency: 7 cycles req-sample to IDLE with constant grant; sample_vld in the 7th cycle.
// Backpressure: stalls in place (no bus activity) while bus_gnt=0; OMSP_TSC_READER_DELTA_EN adds delta.
module omsp_tsc_reader
  import omsp_tsc_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = TSC_BASE_ADDR_DFLT,
  parameter logic [15:0] SNAP_DATA = TSC_SNAP_DATA
) (
  input  logic                     mclk,
  input  logic                     puc_rst_n,
  input  logic                     req,
  omsp_tsc_reader_if.master        bus,
  output logic                     busy,
  output logic                     sample_vld,
  output logic [63:0]              sample,
  output logic [63:0]              delta
);

  localparam logic [13:0] BASE_WADDR = BASE_ADDR[14:1];

  logic [2:0]  r_state;
  logic [47:0] r_asm;
  logic        r_vld;
  logic [63:0] r_sample;
  logic        w_is_rd;
  logic        w_step;
  logic        w_last;
  logic [1:0]  w_word;
  logic [63:0] w_assembled;

  assign w_is_rd     = (r_state >= ST_RD0) && (r_state <= ST_RD3);
  assign w_word      = rd_word(r_state);
  assign w_step      = bus.bus_gnt && (w_is_rd || (r_state == ST_SNAP));
  assign w_last      = bus.bus_gnt && (r_state == ST_RD3);
  // Word 3 arrives on the same edge the sample is published, so take it straight off the bus
  assign w_assembled = {bus.per_dout, r_asm};

  // Bus drive: purely from state and grant; everything zero whenever the grant is absent
  always_comb begin
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.per_addr = 14'h0000;
    bus.per_din  = 16'h0000;
    if (bus.bus_gnt) begin
      if (r_state == ST_SNAP) begin
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b11;
        bus.per_addr = BASE_WADDR + {12'h000, TSC_OFS_W0};
        bus.per_din  = SNAP_DATA;
      end else if (w_is_rd) begin
        bus.per_en   = 1'b1;
        bus.per_addr = BASE_WADDR + {12'h000, w_word};
      end
    end
  end

  // Sequencer: each bus state advances only on a granted cycle
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (req) r_state <= ST_SNAP;
        ST_SNAP, ST_RD0, ST_RD1, ST_RD2, ST_RD3:
                 if (bus.bus_gnt) r_state <= r_state + 3'd1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Assembly of the lower three words as they are read
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_asm <= 48'h0;
    end else if (w_step && w_is_rd) begin
      case (w_word)
        TSC_OFS_W0: r_asm[15:0]  <= bus.per_dout;
        TSC_OFS_W1: r_asm[31:16] <= bus.per_dout;
        TSC_OFS_W2: r_asm[47:32] <= bus.per_dout;
        default:    r_asm        <= r_asm;
      endcase
    end
  end

  // Publish the sample on entry to DONE so sample and sample_vld line up in the DONE cycle
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_vld    <= 1'b0;
      r_sample <= 64'h0;
    end else begin
      r_vld <= w_last;
      if (w_last) r_sample <= w_assembled;
    end
  end

`ifdef OMSP_TSC_READER_DELTA_EN
  logic [63:0] r_prev;
  logic [63:0] r_delta;

  // Difference to the previous completed sample, modulo 2^64
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      r_prev  <= 64'h0;
      r_delta <= 64'h0;
    end else if (w_last) begin
      r_delta <= w_assembled - r_prev;
      r_prev  <= w_assembled;
    end
  end

  assign delta = r_delta;
`else
  assign delta = 64'h0;
`endif

  assign busy       = (r_state != ST_IDLE);
  assign sample_vld = r_vld;
  assign sample     = r_sample;

endmodule

// File: tb/tb_omsp_tsc_reader.sv
// Directed bench for omsp_tsc_reader with a TSC slave model and queue scoreboard.
// Latency: checks sample_vld cycle against request cycle + 6 (+ stall cycles).
// Backpressure: exercises grant loss mid-sequence.
module tb_omsp_tsc_reader;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        req;
  logic        busy;
  logic        sample_vld;
  logic [63:0] sample;
  logic [63:0] delta;

  omsp_tsc_reader_if bus_if();

  omsp_tsc_reader dut (
    .mclk       (mclk),
    .puc_rst_n  (puc_rst_n),
    .req        (req),
    .bus        (bus_if),
    .busy       (busy),
    .sample_vld (sample_vld),
    .sample     (sample),
    .delta      (delta)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  // TSC slave model: live counter value is frozen into snap by the snapshot write
  logic [63:0] live = 64'h0;
  logic [63:0] snap = 64'h0;
  logic [13:0] ofs;

  always @(posedge mclk)
    if (bus_if.per_en && bus_if.per_we == 2'b11) snap <= live;

  always_comb begin
    ofs = bus_if.per_addr - 14'h00C8;
    bus_if.per_dout = 16'h0000;
    if (bus_if.per_en && bus_if.per_we == 2'b00 && ofs < 14'd4)
      bus_if.per_dout = snap[ofs[1:0]*16 +: 16];
  end

  // Scoreboard queues
  logic [31:0] exp_bus[$];  // {addr, we, din}
  logic [63:0] exp_smp[$];
  logic [63:0] exp_dlt[$];
  int          exp_cyc[$];
  logic [63:0] prev_m = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bus(input int nrd);
    exp_bus.push_back({14'h00C8, 2'b11, 16'h0000});
    for (int i = 0; i < nrd; i++) exp_bus.push_back({14'h00C8 + 14'(i), 2'b00, 16'h0000});
  endtask

  task automatic push_seq(input logic [63:0] s, input int vcyc);
    push_bus(4);
    exp_smp.push_back(s);
`ifdef OMSP_TSC_READER_DELTA_EN
    exp_dlt.push_back(s - prev_m);
    prev_m = s;
`else
    exp_dlt.push_back(64'h0);
`endif
    exp_cyc.push_back(vcyc);
  endtask

  // Monitor: pops expectations whenever the DUT shows bus activity or a sample
  always @(negedge mclk) begin
    if (puc_rst_n === 1'b1) begin
      if (!bus_if.bus_gnt)
        chk("bus_idle_no_gnt", {bus_if.per_en, bus_if.per_we, bus_if.per_addr, bus_if.per_din}, 64'h0);
      if (bus_if.per_en) begin
        chk("en_ctx{gnt,busy,vld}", {bus_if.bus_gnt, busy, sample_vld}, 64'b110);
        if (exp_bus.size() == 0) begin
          chk("unexpected_bus_cycle", {bus_if.per_addr, bus_if.per_we}, 64'h0);
        end else begin
          chk("bus_cycle{addr,we,din}", {bus_if.per_addr, bus_if.per_we, bus_if.per_din},
              exp_bus.pop_front());
        end
      end
      if (sample_vld) begin
        if (exp_smp.size() == 0) begin
          chk("unexpected_sample_vld", 64'd1, 64'd0);
        end else begin
          chk("sample", sample, exp_smp.pop_front());
          chk("delta", delta, exp_dlt.pop_front());
          chk("vld_cycle", 64'(cyc), 64'(exp_cyc.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_per_addr"}, 64'(bus_if.per_addr), 64'h0);
    chk({tag, "_per_din"}, 64'(bus_if.per_din), 64'h0);
    chk({tag, "_en_we"}, {bus_if.per_en, bus_if.per_we}, 64'h0);
    chk({tag, "_busy_vld"}, {busy, sample_vld}, 64'h0);
    chk({tag, "_sample"}, sample, 64'h0);
    chk({tag, "_delta"}, delta, 64'h0);
  endtask

  // Request issued in the current cycle (c0); expected sample_vld at c6 + stall
  task automatic start_req(input logic [63:0] s, input int stall);
    live = s;
    req  = 1'b1;
    push_seq(s, cyc + 6 + stall);
    tick();
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_smp.size() != 0 || busy) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) chk({tag, "_timeout"}, 64'd1, 64'd0);
    chk({tag, "_bus_q_left"}, 64'(exp_bus.size()), 64'd0);
    chk({tag, "_smp_q_left"}, 64'(exp_smp.size()), 64'd0);
  endtask

  initial begin
    int k;
    puc_rst_n = 1'b0;
    req       = 1'b0;
    bus_if.bus_gnt = 1'b1;
    repeat (3) tick();
    check_zero("por");
    puc_rst_n = 1'b1;
    tick();

    // Basic read
    start_req(64'h0123_4567_89AB_CDEF, 0);
    wait_idle("basic");
    chk("basic_sample_held", sample, 64'h0123_4567_89AB_CDEF);

    // Word carry pattern
    start_req(64'h0000_FFFF_FFFF_FFFF, 0);
    wait_idle("carry");
    chk("carry_sample_held", sample, 64'h0000_FFFF_FFFF_FFFF);

    // Grant stall of 4 cycles during RD2
    start_req(64'hA5A5_5A5A_1234_8765, 4);
    repeat (3) tick();
    bus_if.bus_gnt = 1'b0;
    repeat (4) tick();
    bus_if.bus_gnt = 1'b1;
    wait_idle("stall");

    // Back-to-back: req held high for 20 cycles -> completions at c6, c13, c20
    live = 64'hDEAD_BEEF_CAFE_F00D;
    k = cyc;
    req = 1'b1;
    push_seq(live, k + 6);
    push_seq(live, k + 13);
    push_seq(live, k + 20);
    repeat (20) tick();
    req = 1'b0;
    wait_idle("b2b");

    // Reset held for 3 cycles starting in RD1
    live = 64'h1111_2222_3333_4444;
    req  = 1'b1;
    push_bus(1);
    tick();
    req = 1'b0;
    repeat (2) tick();
    puc_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("rst_mid");
    end
    puc_rst_n = 1'b1;
    prev_m = 64'h0;
    repeat (10) tick();
    chk("rst_busy_after", 64'(busy), 64'd0);
    chk("rst_bus_q_left", 64'(exp_bus.size()), 64'd0);

    // Delta sequence from a fresh reset
    start_req(64'h0000_0000_FFFF_FFF0, 0);
    wait_idle("dlt1");
`ifdef OMSP_TSC_READER_DELTA_EN
    chk("dlt1_value", delta, 64'h0000_0000_FFFF_FFF0);
`else
    chk("dlt1_value", delta, 64'h0);
`endif
    start_req(64'h0000_0001_0000_0010, 0);
    wait_idle("dlt2");
`ifdef OMSP_TSC_READER_DELTA_EN
    chk("dlt2_value", delta, 64'h20);
`else
    chk("dlt2_value", delta, 64'h0);
`endif
    chk("dlt2_sample", sample, 64'h0000_0001_0000_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
